decomp_seq_ctrl: RTL and testbench
==================================

# decomp_seq_ctrl

Parametrised sequencer for the instruction decompressor that releases up to SLOTS instructions from one compressed fetch word. It sits between the CPU fetch port and the compressed-memory fetch path. It issues compressed fetches, loads the input buffer, and selects the decode-table path and output slot. It serves later CPU requests from the cached word without refetching, and flushes the cache on branch.

## Interface
- SLOTS, 2: maximum instructions packed in one compressed word (2..16).
- IDX_W, $clog2(SLOTS): slot index width.
- CNT_W, $clog2(SLOTS+1): packed-count width.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_req  in  1  CPU requests next instruction; level, held until out_valid.
- branch  in  1  CPU branch taken; one-cycle pulse.
- fetch_valid  in  1  compressed word present on memory data bus this cycle.
- encode  in  1  accompanying word is compressed (1) or raw (0).
- count  in  CNT_W  number of instructions packed in word; sampled with fetch_valid.
- fetch_req  out  1  advance compressed PC and request a word.
- in_buff_load  out  1  load input buffer from memory bus.
- branch_mux  out  1  select branch target into compressed PC.
- table_sel  out  1  1 = decode-table path, 0 = raw bypass.
- slot_sel  out  IDX_W  output slot driven to CPU.
- out_valid  out  1  instruction on output bus valid; serves pending pc_req.
- busy  out  1  fetch outstanding or cached slots remain.

## Operation
- State register: IDLE, FETCH, DRAIN, DISCARD. Register rem (CNT_W) holds slots left. Register idx (IDX_W) holds the next slot.
- Outputs are combinational from state plus inputs (Mealy). All outputs are forced 0 while reset is high.
- IDLE, pc_req & ~branch: fetch_req=1 -> FETCH.
- FETCH, fetch_valid & ~branch: in_buff_load=1, out_valid=1, slot_sel=0, table_sel=encode.
  - encode=0: next state IDLE.
  - encode=1: effective n = count clamped to 1..SLOTS (0 -> 1, >SLOTS -> SLOTS). rem<=n-1, idx<=1. If n==1 -> IDLE, else DRAIN.
- DRAIN, pc_req & ~branch: out_valid=1, table_sel=1, slot_sel=idx; idx<=idx+1, rem<=rem-1. When rem==1 -> IDLE.
- DRAIN without pc_req: hold state, rem and idx.
- Branch, any state: branch_mux=1. rem and idx are cleared, and out_valid and in_buff_load are suppressed that cycle.
  - From IDLE/DRAIN -> IDLE. A pc_req in the same cycle is not served; it is served from IDLE on the next cycle.
  - From FETCH with fetch_valid the same cycle: word dropped -> IDLE.
  - From FETCH without fetch_valid -> DISCARD.
- DISCARD: next fetch_valid is dropped (no load, no out_valid) -> IDLE. A branch in DISCARD stays in DISCARD.
- busy = (state != IDLE).

## Timing
- Latency from pc_req to fetch_req: 0 cycles (same cycle, from IDLE).
- Latency from fetch_valid to out_valid: 0 cycles.
- In DRAIN, pc_req to out_valid: 0 cycles, so one instruction per cycle if pc_req is held.
- Reset values: state=IDLE, rem=0, idx=0. Every output is 0.
- Reset mid-DRAIN or mid-FETCH discards the cache and any outstanding fetch. The first pc_req after release starts a new fetch.
- Fetches are non-overlapping: at most one outstanding. fetch_valid outside FETCH/DISCARD is ignored.

## Configuration
- DECOMP_SEQ_PERF_EN defined: adds outputs fetch_cnt [15:0] and instr_cnt [15:0]. These are saturating counts of accepted fetch words (in_buff_load) and out_valid pulses. Both reset to 0 and hold at 16'hFFFF.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Package decomp_pkg holds the state enum (seq_state_t: IDLE, FETCH, DRAIN, DISCARD) and the saturation constant PERF_MAX = 16'hFFFF.
- Sub-module decomp_sat_cnt is a 16-bit saturating counter with an increment enable. It is instantiated twice, only under DECOMP_SEQ_PERF_EN.

## Test plan
- SLOTS=4, pc_req held, fetch_valid with encode=1, count=4:
  - fetch_req once.
  - out_valid on four consecutive cycles, slot_sel 0,1,2,3.
  - Returns to IDLE; next pc_req raises fetch_req.
- encode=0, count=3: single out_valid with table_sel=0 and slot_sel=0, then IDLE.
- Count clamp cases:
  - count=0 yields 1 out_valid.
  - count=7 with SLOTS=4 yields exactly 4.
- Branch in DRAIN after slot 1 (rem=2): branch_mux=1, no out_valid that cycle, then IDLE. Next cycle pc_req raises fetch_req.
- Branch in FETCH before fetch_valid: next fetch_valid causes no in_buff_load or out_valid. Then one further pc_req produces a new fetch_req.
- Reset asserted in DRAIN: all outputs 0 immediately and busy=0. With DECOMP_SEQ_PERF_EN, counters read 0 and saturate at 16'hFFFF after 65535+ accepted words.

Source files
------------

// File: rtl/decomp_pkg.sv
// decomp_pkg: shared types and constants for the decompressor fetch sequencer.
//   seq_state_t : sequencer states (IDLE, FETCH, DRAIN, DISCARD)
//   PERF_MAX    : saturation value of the 16-bit performance counters
package decomp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DISCARD
    } seq_state_t;

    localparam logic [15:0] PERF_MAX = 16'hFFFF;

endpackage

// File: rtl/decomp_sat_cnt.sv
// decomp_sat_cnt: 16-bit counter that increments on en and sticks at PERF_MAX.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset, clears the count
//   en  : increment request for this cycle
//   cnt : current count
module decomp_sat_cnt
    import decomp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] cnt
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != PERF_MAX)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/decomp_seq_ctrl.sv
// decomp_seq_ctrl: sequencer that issues compressed fetches and releases up to
// SLOTS instructions from each fetched word, one per CPU request.
//   clk, reset    : clock (rising edge) and asynchronous active-high reset
//   pc_req        : CPU wants the next instruction (level)
//   branch        : CPU branch taken (pulse); flushes cached slots
//   fetch_valid   : memory word present; encode/count qualify it
//   fetch_req     : request next compressed word
//   in_buff_load  : capture the memory word into the input buffer
//   branch_mux    : steer branch target into the compressed PC
//   table_sel     : decode-table path (1) or raw bypass (0)
//   slot_sel      : slot of the cached word driven to the CPU
//   out_valid     : instruction on the output bus is valid
//   busy          : fetch outstanding or cached slots remain
// Optional: DECOMP_SEQ_PERF_EN adds fetch_cnt / instr_cnt saturating counters.
module decomp_seq_ctrl
    import decomp_pkg::*;
#(
    parameter int unsigned SLOTS = 2,
    parameter int unsigned IDX_W = $clog2(SLOTS),
    parameter int unsigned CNT_W = $clog2(SLOTS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_req,
    input  logic             branch,
    input  logic             fetch_valid,
    input  logic             encode,
    input  logic [CNT_W-1:0] count,
    output logic             fetch_req,
    output logic             in_buff_load,
    output logic             branch_mux,
    output logic             table_sel,
    output logic [IDX_W-1:0] slot_sel,
    output logic             out_valid,
    output logic             busy
`ifdef DECOMP_SEQ_PERF_EN
    ,
    output logic [15:0]      fetch_cnt,
    output logic [15:0]      instr_cnt
`endif
);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] n_eff;

    // Packed count clamped to 1..SLOTS.
    always_comb begin
        if (count == '0) begin
            n_eff = CNT_W'(1);
        end else if (count > CNT_W'(SLOTS)) begin
            n_eff = CNT_W'(SLOTS);
        end else begin
            n_eff = count;
        end
    end

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        idx_d        = idx_q;
        fetch_req    = 1'b0;
        in_buff_load = 1'b0;
        branch_mux   = 1'b0;
        table_sel    = 1'b0;
        slot_sel     = '0;
        out_valid    = 1'b0;

        if (branch) begin
            branch_mux = 1'b1;
            rem_d      = '0;
            idx_d      = '0;
            case (state_q)
                FETCH:   state_d = fetch_valid ? IDLE : DISCARD;
                DISCARD: state_d = DISCARD;
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (pc_req) begin
                        fetch_req = 1'b1;
                        state_d   = FETCH;
                    end
                end
                FETCH: begin
                    if (fetch_valid) begin
                        in_buff_load = 1'b1;
                        out_valid    = 1'b1;
                        table_sel    = encode;
                        if (encode) begin
                            rem_d   = n_eff - CNT_W'(1);
                            idx_d   = IDX_W'(1);
                            state_d = (n_eff == CNT_W'(1)) ? IDLE : DRAIN;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (pc_req) begin
                        out_valid = 1'b1;
                        table_sel = 1'b1;
                        slot_sel  = idx_q;
                        idx_d     = idx_q + IDX_W'(1);
                        rem_d     = rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state_d = IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (fetch_valid) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Outputs are combinational, so they must be masked while reset is held.
        if (reset) begin
            fetch_req    = 1'b0;
            in_buff_load = 1'b0;
            branch_mux   = 1'b0;
            table_sel    = 1'b0;
            slot_sel     = '0;
            out_valid    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
        end
    end

    assign busy = ~reset & (state_q != IDLE);

`ifdef DECOMP_SEQ_PERF_EN
    decomp_sat_cnt u_fetch_cnt (
        .clk (clk),
        .rst (reset),
        .en  (in_buff_load),
        .cnt (fetch_cnt)
    );

    decomp_sat_cnt u_instr_cnt (
        .clk (clk),
        .rst (reset),
        .en  (out_valid),
        .cnt (instr_cnt)
    );
`endif

endmodule

// File: tb/tb_decomp_seq_ctrl.sv
// tb_decomp_seq_ctrl: directed scenarios with literal expectations followed by
// randomized traffic, all checked every cycle against a slot-queue model.
module tb_decomp_seq_ctrl;

    localparam int unsigned SLOTS = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             pc_req;
    logic             branch;
    logic             fetch_valid;
    logic             encode;
    logic [CNT_W-1:0] count;
    logic             fetch_req;
    logic             in_buff_load;
    logic             branch_mux;
    logic             table_sel;
    logic [IDX_W-1:0] slot_sel;
    logic             out_valid;
    logic             busy;
`ifdef DECOMP_SEQ_PERF_EN
    logic [15:0]      fetch_cnt;
    logic [15:0]      instr_cnt;
`endif

    decomp_seq_ctrl #(.SLOTS(SLOTS)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_req       (pc_req),
        .branch       (branch),
        .fetch_valid  (fetch_valid),
        .encode       (encode),
        .count        (count),
        .fetch_req    (fetch_req),
        .in_buff_load (in_buff_load),
        .branch_mux   (branch_mux),
        .table_sel    (table_sel),
        .slot_sel     (slot_sel),
        .out_valid    (out_valid),
        .busy         (busy)
`ifdef DECOMP_SEQ_PERF_EN
        ,
        .fetch_cnt    (fetch_cnt),
        .instr_cnt    (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a fetch flag, a drop-next flag and the list of slots
    // still cached (next slot number and how many remain).
    bit m_fetch, m_drop;
    int m_left, m_next;
    int m_fc, m_ic;
    bit e_fr, e_ld, e_bm, e_ts, e_ov, e_busy;
    int e_slot;

    task automatic model(input bit commit);
        int n;
        e_fr = 0; e_ld = 0; e_bm = 0; e_ts = 0; e_ov = 0; e_busy = 0; e_slot = 0;
        if (reset) begin
            if (commit) begin
                m_fetch = 0; m_drop = 0; m_left = 0; m_next = 0; m_fc = 0; m_ic = 0;
            end
            return;
        end
        e_busy = m_fetch || m_drop || (m_left > 0);
        if (branch) begin
            e_bm = 1;
            if (commit) begin
                if (m_fetch && !fetch_valid) m_drop = 1;
                m_fetch = 0; m_left = 0; m_next = 0;
            end
        end else if (m_drop) begin
            if (commit && fetch_valid) m_drop = 0;
        end else if (m_fetch) begin
            if (fetch_valid) begin
                e_ld = 1; e_ov = 1; e_ts = encode; e_slot = 0;
                if (commit) begin
                    m_fetch = 0;
                    if (encode) begin
                        n = int'(count);
                        if (n == 0) n = 1;
                        if (n > int'(SLOTS)) n = int'(SLOTS);
                        m_left = n - 1;
                        m_next = 1;
                    end
                end
            end
        end else if (m_left > 0) begin
            if (pc_req) begin
                e_ov = 1; e_ts = 1; e_slot = m_next;
                if (commit) begin
                    m_next++;
                    m_left--;
                end
            end
        end else if (pc_req) begin
            e_fr = 1;
            if (commit) m_fetch = 1;
        end
        if (commit) begin
            if (e_ld && m_fc < 65535) m_fc++;
            if (e_ov && m_ic < 65535) m_ic++;
        end
    endtask

    // Compare process: outputs checked mid-cycle, model advanced on the edge.
    initial begin
        forever begin
            @(negedge clk);
            model(0);
            check("outputs {fr,ld,bm,ts,ov,busy,slot}",
                  int'({fetch_req, in_buff_load, branch_mux, table_sel, out_valid, busy, slot_sel}),
                  int'({e_fr, e_ld, e_bm, e_ts, e_ov, e_busy, 2'(e_slot)}));
`ifdef DECOMP_SEQ_PERF_EN
            check("fetch_cnt", int'(fetch_cnt), m_fc);
            check("instr_cnt", int'(instr_cnt), m_ic);
`endif
            @(posedge clk);
            model(1);
        end
    end

    logic s_fr, s_ld, s_bm, s_ts, s_ov, s_busy;
    int   s_slot;

    task automatic step(input bit pc, input bit br, input bit fv, input bit enc, input int cnt);
        pc_req = pc; branch = br; fetch_valid = fv; encode = enc; count = CNT_W'(cnt);
        @(negedge clk);
        s_fr = fetch_req; s_ld = in_buff_load; s_bm = branch_mux; s_ts = table_sel;
        s_ov = out_valid; s_busy = busy; s_slot = int'(slot_sel);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; pc_req = 1'b0; branch = 1'b0; fetch_valid = 1'b0; encode = 1'b0; count = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", int'(busy), 0);
        check("reset out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Full word of four slots.
        step(1, 0, 0, 0, 0); check("fetch_req from idle", int'(s_fr), 1);
        step(1, 0, 1, 1, 4); check("slot0 valid", int'(s_ov), 1);
        check("slot0 sel", s_slot, 0); check("slot0 load", int'(s_ld), 1);
        check("slot0 table", int'(s_ts), 1);
        for (int i = 1; i < 4; i++) begin
            step(1, 0, 0, 0, 0);
            check("drain valid", int'(s_ov), 1);
            check("drain slot", s_slot, i);
            check("drain no fetch", int'(s_fr), 0);
        end
        step(1, 0, 0, 0, 0); check("refetch after drain", int'(s_fr), 1);

        // Raw word.
        step(1, 0, 1, 0, 3); check("raw valid", int'(s_ov), 1);
        check("raw table_sel", int'(s_ts), 0); check("raw slot", s_slot, 0);
        step(1, 0, 0, 0, 0); check("raw back to idle", int'(s_fr), 1);

        // count=0 gives one slot.
        step(1, 0, 1, 1, 0); check("count0 valid", int'(s_ov), 1);
        step(1, 0, 0, 0, 0); check("count0 single", int'(s_fr), 1);

        // count=7 clamps to four slots.
        step(1, 0, 1, 1, 7); check("count7 slot0", int'(s_ov), 1);
        for (int i = 1; i < 4; i++) begin
            step(1, 0, 0, 0, 0); check("count7 drain", s_slot, i);
        end
        step(1, 0, 0, 0, 0); check("count7 exactly four", int'(s_fr), 1);

        // Branch in DRAIN after slot 1.
        step(1, 0, 1, 1, 4);
        step(1, 0, 0, 0, 0); check("pre-branch slot1", s_slot, 1);
        step(1, 1, 0, 0, 0); check("drain branch_mux", int'(s_bm), 1);
        check("drain branch no valid", int'(s_ov), 0);
        step(1, 0, 0, 0, 0); check("post-branch fetch", int'(s_fr), 1);

        // Branch in FETCH before the word arrives.
        step(0, 1, 0, 0, 0); check("fetch branch_mux", int'(s_bm), 1);
        step(0, 0, 1, 1, 4); check("discard no load", int'(s_ld), 0);
        check("discard no valid", int'(s_ov), 0); check("discard busy", int'(s_busy), 1);
        step(1, 0, 0, 0, 0); check("fetch after discard", int'(s_fr), 1);

        // Reset while draining.
        step(1, 0, 1, 1, 4);
        reset = 1'b1;
        step(1, 0, 0, 0, 0);
        check("reset in drain outputs", int'({s_fr, s_ld, s_bm, s_ts, s_ov, s_busy}), 0);
        check("reset in drain slot", s_slot, 0);
`ifdef DECOMP_SEQ_PERF_EN
        check("reset fetch_cnt", int'(fetch_cnt), 0);
        check("reset instr_cnt", int'(instr_cnt), 0);
`endif
        reset = 1'b0;
        step(1, 0, 0, 0, 0); check("fetch after reset", int'(s_fr), 1);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(199) == 0) reset = 1'b1;
            step(($urandom_range(3) != 0), ($urandom_range(15) == 0),
                 ($urandom_range(1) == 1), ($urandom_range(3) != 0),
                 int'($urandom_range(7)));
            reset = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
